// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares the single instruction-ROM read port between the fetch stage and a
//   data-side read port. Each access runs IDLE -> BUSY -> RESP -> IDLE. The
//   result goes back to the port that won arbitration, with a one-cycle valid
//   pulse. A branch flush discards an outstanding fetch result. The ROM access
//   itself still runs to completion.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   if_req, if_addr     fetch read request and address (pc)
//   if_data, if_valid   instruction returned to fetch, one-cycle valid pulse
//   if_stall            stall to fetch: if_req & ~if_valid
//   flush               branch taken; drop the outstanding fetch result
//   d_req, d_addr       data-port read request and address
//   d_data, d_valid     data returned to data port, one-cycle valid pulse
//   rom_address         registered ROM address
//   rom_data            ROM read data, valid ROM_LATENCY cycles after address
module rom_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ROM_LATENCY  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              flush,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_data,
    output logic              d_valid,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int CNT_W = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LATENCY);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic             owner_if;
    logic             drop;
    logic [CNT_W-1:0] cnt;
    logic [STV_W-1:0] starve;
    logic             grant_d;
    logic             grant_if;
    logic             rom_ready;

    // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_d  = d_req && !(if_req && (starve == STV_MAX));
        grant_if = if_req && !grant_d;
    end

    assign rom_ready = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_d || grant_if) state_next = BUSY;
            BUSY:    if (rom_ready) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs. A flush in the same cycle as the fetch pulse suppresses the
    // pulse combinationally. The drop flag covers a flush seen earlier.
    always_comb begin
        if_valid = (state == RESP) && owner_if && !drop && !flush;
        d_valid  = (state == RESP) && !owner_if;
        if_stall = if_req && !if_valid;
    end

    // Datapath: address latch, owner, latency counter, starve counter,
    // drop flag, data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_address <= '0;
            owner_if    <= 1'b0;
            cnt         <= '0;
            starve      <= '0;
            drop        <= 1'b0;
            if_data     <= '0;
            d_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d || grant_if) begin
                        rom_address <= grant_d ? d_addr : if_addr;
                        owner_if    <= grant_if;
                        cnt         <= '0;
                        if (grant_d && if_req) begin
                            if (starve != STV_MAX) starve <= starve + STV_W'(1);
                        end else begin
                            starve <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (rom_ready) begin
                        if (owner_if) if_data <= rom_data;
                        else          d_data  <= rom_data;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (state_next == IDLE) begin
                drop <= 1'b0;
            end else if (flush && owner_if && (state != IDLE)) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT0: ROM_LATENCY=1, STARVE_LIMIT=2
    logic        if_req0, d_req0, flush0;
    logic [31:0] if_addr0, d_addr0;
    logic [31:0] if_data0, d_data0, rom_address0, rom_data0;
    logic        if_valid0, d_valid0, if_stall0;

    // DUT1: ROM_LATENCY=0, STARVE_LIMIT=4
    logic        if_req1, d_req1, flush1;
    logic [31:0] if_addr1, d_addr1;
    logic [31:0] if_data1, d_data1, rom_address1, rom_data1;
    logic        if_valid1, d_valid1, if_stall1;

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LATENCY(1), .STARVE_LIMIT(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_data(if_data0),
        .if_valid(if_valid0), .if_stall(if_stall0), .flush(flush0),
        .d_req(d_req0), .d_addr(d_addr0), .d_data(d_data0), .d_valid(d_valid0),
        .rom_address(rom_address0), .rom_data(rom_data0)
    );

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LATENCY(0), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_data(if_data1),
        .if_valid(if_valid1), .if_stall(if_stall1), .flush(flush1),
        .d_req(d_req1), .d_addr(d_addr1), .d_data(d_data1), .d_valid(d_valid1),
        .rom_address(rom_address1), .rom_data(rom_data1)
    );

    // ROM models: {addr[15:0], 16'hA5A5}, one-cycle and zero-cycle latency.
    always @(posedge clk) rom_data0 <= {rom_address0[15:0], 16'hA5A5};
    assign rom_data1 = {rom_address1[15:0], 16'hA5A5};

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic is_if, input logic [31:0] data);
        exp_t e;
        e.is_if = is_if;
        e.data  = data;
        return e;
    endfunction

    // Scoreboard monitors: every valid pulse is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (if_valid0 || d_valid0) begin
            n_vec++;
            if (if_valid0 && d_valid0) begin
                n_bad++;
                $display("FAIL dut0_both_valid: got both valids, expected one");
            end else if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL dut0_unexpected: got if_valid=%b d_valid=%b, expected no pulse",
                         if_valid0, d_valid0);
            end else begin
                e = q0.pop_front();
                if (if_valid0 !== e.is_if || (if_valid0 ? if_data0 : d_data0) !== e.data) begin
                    n_bad++;
                    $display("FAIL dut0_resp: got port_if=%b data=%h, expected port_if=%b data=%h",
                             if_valid0, if_valid0 ? if_data0 : d_data0, e.is_if, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if_valid1 || d_valid1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL dut1_unexpected: got if_valid=%b d_valid=%b, expected no pulse",
                         if_valid1, d_valid1);
            end else begin
                e = q1.pop_front();
                if (if_valid1 !== e.is_if || (if_valid1 ? if_data1 : d_data1) !== e.data) begin
                    n_bad++;
                    $display("FAIL dut1_resp: got port_if=%b data=%h, expected port_if=%b data=%h",
                             if_valid1, if_valid1 ? if_data1 : d_data1, e.is_if, e.data);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Both ports request continuously; each port moves to its next address
    // (+4) after its valid pulse. Returns at the start of the IDLE cycle after
    // the last expected pulse with both requests dropped.
    task automatic run_contend(input int nvalid, input int budget);
        int seen = 0;
        int cyc  = 0;
        logic dv, iv;
        d_req0  = 1'b1;
        if_req0 = 1'b1;
        while (seen < nvalid && cyc < budget) begin
            @(negedge clk);
            dv = d_valid0;
            iv = if_valid0;
            tick();
            cyc++;
            if (dv) begin d_addr0 = d_addr0 + 32'd4; seen++; end
            if (iv) begin if_addr0 = if_addr0 + 32'd4; seen++; end
        end
        d_req0  = 1'b0;
        if_req0 = 1'b0;
        chk("contend_pulses", seen, nvalid);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        if_req0 = 0; d_req0 = 0; flush0 = 0; if_addr0 = '0; d_addr0 = '0;
        if_req1 = 0; d_req1 = 0; flush1 = 0; if_addr1 = '0; d_addr1 = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_if_valid", 32'(if_valid0), 32'd0);
        chk("rst_d_valid", 32'(d_valid0), 32'd0);
        chk("rst_if_stall", 32'(if_stall0), 32'd0);
        chk("rst_rom_address", rom_address0, 32'd0);
        chk("rst_if_data", if_data0, 32'd0);
        chk("rst_d_data", d_data0, 32'd0);
        chk("rst1_rom_address", rom_address1, 32'd0);

        // Single fetch, ROM_LATENCY=1
        tick();                                      // cycle 0
        if_req0 = 1'b1; if_addr0 = 32'h10;
        q0.push_back(mk(1'b1, 32'h0010A5A5));
        @(negedge clk); chk("fetch_c0_stall", 32'(if_stall0), 32'd1);
        tick(); @(negedge clk);                      // cycle 1
        chk("fetch_c1_addr", rom_address0, 32'h10);
        chk("fetch_c1_stall", 32'(if_stall0), 32'd1);
        tick(); @(negedge clk);                      // cycle 2
        chk("fetch_c2_addr", rom_address0, 32'h10);
        chk("fetch_c2_stall", 32'(if_stall0), 32'd1);
        tick(); @(negedge clk);                      // cycle 3
        chk("fetch_c3_valid", 32'(if_valid0), 32'd1);
        chk("fetch_c3_data", if_data0, 32'h0010A5A5);
        chk("fetch_c3_stall", 32'(if_stall0), 32'd0);
        tick(); if_req0 = 1'b0;                      // cycle 4
        @(negedge clk); chk("fetch_c4_valid", 32'(if_valid0), 32'd0);

        // Contention, STARVE_LIMIT=2: D, D, IF, D, D, IF
        tick();
        d_addr0 = 32'h100; if_addr0 = 32'h200;
        q0.push_back(mk(1'b0, 32'h0100A5A5));
        q0.push_back(mk(1'b0, 32'h0104A5A5));
        q0.push_back(mk(1'b1, 32'h0200A5A5));
        q0.push_back(mk(1'b0, 32'h0108A5A5));
        q0.push_back(mk(1'b0, 32'h010CA5A5));
        q0.push_back(mk(1'b1, 32'h0204A5A5));
        run_contend(6, 60);

        // Flush mid-fetch: 0x20 dropped, branch target 0x40 fetched next
        if_req0 = 1'b1; if_addr0 = 32'h20;           // cycle 0
        q0.push_back(mk(1'b1, 32'h0040A5A5));
        tick(); flush0 = 1'b1; if_addr0 = 32'h40;    // cycle 1
        @(negedge clk); chk("flush_c1_addr", rom_address0, 32'h20);
        tick(); flush0 = 1'b0;                       // cycle 2
        @(negedge clk); chk("flush_c2_addr", rom_address0, 32'h20);
        tick(); @(negedge clk);                      // cycle 3
        chk("flush_c3_valid", 32'(if_valid0), 32'd0);
        tick(); @(negedge clk);                      // cycle 4
        chk("flush_c4_stall", 32'(if_stall0), 32'd1);
        tick(); @(negedge clk);                      // cycle 5
        chk("flush_c5_addr", rom_address0, 32'h40);
        tick();                                      // cycle 6
        tick(); @(negedge clk);                      // cycle 7
        chk("flush_c7_valid", 32'(if_valid0), 32'd1);
        tick(); if_req0 = 1'b0;                      // cycle 8

        // Flush while the data port owns the ROM has no effect
        d_req0 = 1'b1; d_addr0 = 32'h30;
        q0.push_back(mk(1'b0, 32'h0030A5A5));
        tick(); flush0 = 1'b1;
        tick(); flush0 = 1'b0;
        tick(); @(negedge clk);
        chk("dflush_c3_valid", 32'(d_valid0), 32'd1);
        tick(); d_req0 = 1'b0;

        // Flush in the same cycle as the fetch pulse suppresses it
        if_req0 = 1'b1; if_addr0 = 32'h50;
        tick(); tick();
        tick(); flush0 = 1'b1;                       // cycle 3 (RESP)
        @(negedge clk);
        chk("vflush_c3_valid", 32'(if_valid0), 32'd0);
        chk("vflush_c3_stall", 32'(if_stall0), 32'd1);
        tick(); flush0 = 1'b0; if_req0 = 1'b0;

        // Reset during BUSY of a data read (starve counter made nonzero first)
        d_req0 = 1'b1; d_addr0 = 32'h60;
        if_req0 = 1'b1; if_addr0 = 32'h70;
        tick(); rst = 1'b1; d_req0 = 1'b0; if_req0 = 1'b0;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rstmid_d_valid", 32'(d_valid0), 32'd0);
        chk("rstmid_if_valid", 32'(if_valid0), 32'd0);
        chk("rstmid_rom_address", rom_address0, 32'd0);
        chk("rstmid_d_data", d_data0, 32'd0);
        chk("rstmid_if_data", if_data0, 32'd0);
        chk("rstmid_if_stall", 32'(if_stall0), 32'd0);
        // A cleared starve counter gives D, D, IF again
        tick();
        d_addr0 = 32'h300; if_addr0 = 32'h400;
        q0.push_back(mk(1'b0, 32'h0300A5A5));
        q0.push_back(mk(1'b0, 32'h0304A5A5));
        q0.push_back(mk(1'b1, 32'h0400A5A5));
        run_contend(3, 40);

        // Combinational ROM, data read of 0x8
        tick();                                      // cycle 0
        d_req1 = 1'b1; d_addr1 = 32'h8;
        q1.push_back(mk(1'b0, 32'h0008A5A5));
        @(negedge clk); chk("comb_c0_valid", 32'(d_valid1), 32'd0);
        tick(); @(negedge clk);                      // cycle 1
        chk("comb_c1_valid", 32'(d_valid1), 32'd0);
        chk("comb_c1_addr", rom_address1, 32'h8);
        tick(); @(negedge clk);                      // cycle 2
        chk("comb_c2_valid", 32'(d_valid1), 32'd1);
        chk("comb_c2_data", d_data1, 32'h0008A5A5);
        tick(); d_req1 = 1'b0;

        repeat (6) tick();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
